// File: rtl/mig_write_issuer.sv
// mig_write_issuer
// Takes one 128-bit phrase at a time from an AXI-Stream style input and
// issues it to a MIG UI as one write command plus one write-data beat. The
// command and data channels are handshaked independently. Addresses advance
// by ADDR_INCR per phrase and wrap to BASE_ADDR after FRAME_PHRASES phrases
// or whenever tuser_in marks a new frame.
//
// Handshakes: a transfer happens on a channel in every cycle where its valid
// (valid_in / app_en / app_wdf_wren) and its ready (ready_in / app_rdy /
// app_wdf_rdy) are both high at the rising edge of clk_in. A valid stays high
// until its transfer happens. ready_in may depend combinationally on app_rdy
// and app_wdf_rdy so that back-to-back phrases stream at one per cycle.
module mig_write_issuer #(
  parameter int ADDR_WIDTH    = 27,
  parameter int ADDR_INCR     = 8,
  parameter int BASE_ADDR     = 0,
  parameter int FRAME_PHRASES = 76800
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  calib_done_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [127:0]          data_in,
  input  logic                  tuser_in,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  output logic [127:0]          app_wdf_data,
  output logic [15:0]           app_wdf_mask,
  output logic                  frame_done_out,
  output logic                  state_dbg
);

  localparam int IDX_W = (FRAME_PHRASES > 1) ? $clog2(FRAME_PHRASES) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(FRAME_PHRASES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] INCR     = ADDR_WIDTH'(ADDR_INCR);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                  state;
  logic                    cmd_sent;
  logic                    data_sent;
  logic [IDX_W-1:0]        cur_idx;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [IDX_W-1:0]        next_idx;

  logic                    cmd_done;
  logic                    data_done;
  logic                    complete;
  logic                    capture;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [IDX_W-1:0]        cap_idx;
  logic                    cap_last;

  // Channel valids are decoded from state and the per-channel sent flags.
  assign app_en       = (state == ISSUE) && !cmd_sent;
  assign app_wdf_wren = (state == ISSUE) && !data_sent;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = 3'b000;
  assign app_wdf_mask = 16'h0000;
  assign state_dbg    = state;

  // Phrase completion: each channel is done either from an earlier
  // handshake or from a handshake happening in this cycle.
  always_comb begin
    cmd_done  = cmd_sent  || (app_en && app_rdy);
    data_done = data_sent || (app_wdf_wren && app_wdf_rdy);
    complete  = (state == ISSUE) && cmd_done && data_done;
    ready_in  = !rst_in && calib_done_in && ((state == IDLE) || complete);
    capture   = valid_in && ready_in;
  end

  // Address/index of a phrase being captured; tuser_in restarts the frame.
  always_comb begin
    cap_addr = tuser_in ? BASE : next_addr;
    cap_idx  = tuser_in ? '0   : next_idx;
    cap_last = (cap_idx == LAST_IDX);
  end

  // Main FSM: capture, per-channel progress, completion and frame pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      cmd_sent       <= 1'b0;
      data_sent      <= 1'b0;
      cur_idx        <= '0;
      next_addr      <= BASE;
      next_idx       <= '0;
      app_addr       <= BASE;
      app_wdf_data   <= '0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= complete && (cur_idx == LAST_IDX);
      if (capture) begin
        // The follow-on address is fixed by the captured phrase, so it is
        // computed here rather than at completion.
        state        <= ISSUE;
        app_addr     <= cap_addr;
        cur_idx      <= cap_idx;
        app_wdf_data <= data_in;
        cmd_sent     <= 1'b0;
        data_sent    <= 1'b0;
        next_addr    <= cap_last ? BASE : (cap_addr + INCR);
        next_idx     <= cap_last ? '0   : (cap_idx + IDX_W'(1));
      end else if (complete) begin
        state     <= IDLE;
        cmd_sent  <= 1'b0;
        data_sent <= 1'b0;
      end else if (state == ISSUE) begin
        if (app_en && app_rdy)
          cmd_sent <= 1'b1;
        if (app_wdf_wren && app_wdf_rdy)
          data_sent <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mig_write_issuer.sv
// tb_mig_write_issuer
// Cycle-table bench for mig_write_issuer with a four-phrase frame, plus a
// hand-written asynchronous reset sequence.
module tb_mig_write_issuer;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         calib_done_in = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in;
  logic [127:0] data_in = '0;
  logic         tuser_in = 1'b0;
  logic         app_en;
  logic         app_rdy = 1'b0;
  logic [2:0]   app_cmd;
  logic [26:0]  app_addr;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy = 1'b0;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         frame_done_out;
  logic         state_dbg;

  mig_write_issuer #(
    .ADDR_WIDTH(27), .ADDR_INCR(8), .BASE_ADDR(0), .FRAME_PHRASES(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .calib_done_in(calib_done_in),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .tuser_in(tuser_in), .app_en(app_en), .app_rdy(app_rdy),
    .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .frame_done_out(frame_done_out), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        valid;
    logic        tuser;
    logic        calib;
    logic        rdy;
    logic        wrdy;
    logic [31:0] tag;
    logic        e_ready;
    logic        e_en;
    logic        e_wren;
    logic [26:0] e_addr;
    logic        e_done;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_cmd_hs = 0;
  int          n_data_hs = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic v, input logic tu, input logic ca, input logic r,
                     input logic wr, input logic [31:0] tg, input logic er,
                     input logic ee, input logic ew, input logic [26:0] ea,
                     input logic ed);
    vec_t x;
    x.valid = v; x.tuser = tu; x.calib = ca; x.rdy = r; x.wrdy = wr; x.tag = tg;
    x.e_ready = er; x.e_en = ee; x.e_wren = ew; x.e_addr = ea; x.e_done = ed;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic v, input logic tu, input logic ca, input logic r,
                       input logic wr, input logic [31:0] tg);
    valid_in = v; tuser_in = tu; calib_done_in = ca; app_rdy = r; app_wdf_rdy = wr;
    data_in = {4{tg}};
  endtask

  initial begin
    // streaming, frame wrap after 4 phrases, frame_done the cycle after
    add(1,1,1,1,1,32'hA0, 1,0,0,0,0);
    add(1,0,1,1,1,32'hA1, 1,1,1,0,0);
    add(1,0,1,1,1,32'hA2, 1,1,1,8,0);
    add(1,0,1,1,1,32'hA3, 1,1,1,16,0);
    add(1,0,1,1,1,32'hA4, 1,1,1,24,0);
    add(1,0,1,1,1,32'hA5, 1,1,1,0,1);
    add(0,0,1,1,1,32'h0,  1,1,1,8,0);
    add(0,0,1,1,1,32'h0,  1,0,0,0,0);
    // tuser on phrase 3 restarts the frame; only the restarted frame finishes
    add(1,1,1,1,1,32'hB0, 1,0,0,0,0);
    add(1,0,1,1,1,32'hB1, 1,1,1,0,0);
    add(1,1,1,1,1,32'hB2, 1,1,1,8,0);
    add(1,0,1,1,1,32'hB3, 1,1,1,0,0);
    add(1,0,1,1,1,32'hB4, 1,1,1,8,0);
    add(1,0,1,1,1,32'hB5, 1,1,1,16,0);
    add(0,0,1,1,1,32'h0,  1,1,1,24,0);
    add(0,0,1,1,1,32'h0,  1,0,0,0,1);
    // app_rdy low for 3 cycles while write data is accepted at once
    add(1,1,1,0,1,32'hC0, 1,0,0,0,0);
    add(1,0,1,0,1,32'hC1, 0,1,1,0,0);
    add(1,0,1,0,1,32'hC1, 0,1,0,0,0);
    add(1,0,1,0,1,32'hC1, 0,1,0,0,0);
    add(1,0,1,1,1,32'hC1, 1,1,0,0,0);
    add(0,0,1,1,1,32'h0,  1,1,1,8,0);
    add(0,0,1,1,1,32'h0,  1,0,0,0,0);
    // calibration gating; an issued phrase still completes with calib low
    add(1,1,0,1,1,32'hD0, 0,0,0,0,0);
    add(1,1,0,1,1,32'hD0, 0,0,0,0,0);
    add(1,1,1,1,1,32'hD0, 1,0,0,0,0);
    add(1,0,1,1,1,32'hD1, 1,1,1,0,0);
    add(0,0,0,0,1,32'h0,  0,1,1,8,0);
    add(0,0,0,1,1,32'h0,  0,1,0,8,0);
    add(0,0,0,1,1,32'h0,  0,0,0,0,0);
    add(0,0,1,1,1,32'h0,  1,0,0,0,0);

    // reset state
    #12;
    chk("rst_ready", ready_in, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_end", app_wdf_end, 0);
    chk("rst_done", frame_done_out, 0);
    chk("rst_addr", app_addr, 0);
    chk("rst_data", app_wdf_data, 0);
    chk("rst_state", state_dbg, 0);
    calib_done_in = 1'b1;
    #1;
    chk("rst_ready_calib", ready_in, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // table
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk_in);
      #1;
      drive(tbl[i].valid, tbl[i].tuser, tbl[i].calib, tbl[i].rdy, tbl[i].wrdy, tbl[i].tag);
      @(negedge clk_in);
      chk($sformatf("c%0d_ready", i), ready_in, tbl[i].e_ready);
      chk($sformatf("c%0d_app_en", i), app_en, tbl[i].e_en);
      chk($sformatf("c%0d_wren", i), app_wdf_wren, tbl[i].e_wren);
      chk($sformatf("c%0d_end", i), app_wdf_end, tbl[i].e_wren);
      chk($sformatf("c%0d_done", i), frame_done_out, tbl[i].e_done);
      if (tbl[i].e_en) chk($sformatf("c%0d_addr", i), app_addr, tbl[i].e_addr);
      if (app_en) begin
        chk($sformatf("c%0d_cmd", i), app_cmd, 0);
      end
      if (app_wdf_wren) chk($sformatf("c%0d_mask", i), app_wdf_mask, 0);
      // scoreboard: data beats must appear in capture order
      if (tbl[i].valid && tbl[i].e_ready) exp_q.push_back(tbl[i].tag);
      if (app_en && app_rdy) n_cmd_hs++;
      if (app_wdf_wren && app_wdf_rdy) begin
        n_data_hs++;
        if (exp_q.size() == 0) chk($sformatf("c%0d_extra_beat", i), 1, 0);
        else begin
          logic [31:0] t;
          t = exp_q.pop_front();
          chk($sformatf("c%0d_data", i), app_wdf_data, {4{t}});
        end
      end
    end
    chk("sb_queue_empty", exp_q.size(), 0);
    chk("cmd_hs_count", n_cmd_hs, 16);
    chk("data_hs_count", n_data_hs, 16);

    // asynchronous reset during ISSUE abandons the phrase
    @(posedge clk_in);
    #1;
    drive(1, 0, 1, 0, 0, 32'hE0);
    @(negedge clk_in);
    chk("pre_rst_ready", ready_in, 1);
    @(posedge clk_in);
    #1;
    drive(0, 0, 1, 0, 0, 32'h0);
    @(negedge clk_in);
    chk("pre_rst_en", app_en, 1);
    chk("pre_rst_wren", app_wdf_wren, 1);
    chk("pre_rst_addr", app_addr, 16);
    chk("pre_rst_data", app_wdf_data, {4{32'hE0}});
    #2;
    rst_in = 1'b1;
    #1;
    chk("async_rst_en", app_en, 0);
    chk("async_rst_wren", app_wdf_wren, 0);
    chk("async_rst_ready", ready_in, 0);
    chk("async_rst_addr", app_addr, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    @(posedge clk_in);
    #1;
    chk("post_rst_no_retry", app_en, 0);
    drive(1, 0, 1, 1, 1, 32'hF0);
    @(negedge clk_in);
    chk("post_rst_ready", ready_in, 1);
    @(posedge clk_in);
    #1;
    drive(0, 0, 1, 1, 1, 32'h0);
    @(negedge clk_in);
    chk("post_rst_en", app_en, 1);
    chk("post_rst_addr", app_addr, 0);
    chk("post_rst_data", app_wdf_data, {4{32'hF0}});
    @(posedge clk_in);
    #1;
    chk("post_rst_idle", app_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mig_write_issuer.md
MIG_WRITE_ISSUER -- requirements
Module: mig_write_issuer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, width of MIG UI app_addr.
REQ-002 SHALL have parameter ADDR_INCR, default 8, address step per 128-bit phrase.
REQ-003 SHALL have parameter BASE_ADDR, default 0, address of the first phrase of every frame.
REQ-004 SHALL have parameter FRAME_PHRASES, default 76800, phrases per frame before the address wraps to BASE_ADDR.
REQ-005 SHALL have port clk_in  input  1  the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port calib_done_in  input  1  MIG init_calib_complete.
REQ-008 SHALL have ports valid_in input 1, ready_in output 1, data_in input 128, tuser_in input 1: AXI-Stream phrase input; tuser_in=1 marks the first phrase of a frame.
REQ-009 SHALL have ports app_en output 1, app_rdy input 1, app_cmd output 3, app_addr output ADDR_WIDTH: MIG command channel.
REQ-010 SHALL have ports app_wdf_wren output 1, app_wdf_end output 1, app_wdf_rdy input 1, app_wdf_data output 128, app_wdf_mask output 16: MIG write-data channel.
REQ-011 SHALL have port frame_done_out  output  1  one-cycle pulse when the last phrase of a frame completes.

Function
REQ-012 SHALL implement states IDLE and ISSUE; a phrase is captured only on valid_in && ready_in.
REQ-013 On capture: latch data_in into a 128-bit hold register; latch app_addr = BASE_ADDR and phrase index 0 if tuser_in=1, else the running next address and next index; clear cmd_sent and data_sent; enter ISSUE.
REQ-014 In ISSUE: app_en = ~cmd_sent; app_wdf_wren = ~data_sent; app_wdf_end = app_wdf_wren; app_cmd = 3'b000 always; app_wdf_mask = 16'h0000 always.
REQ-015 cmd_sent SHALL set on app_en && app_rdy; data_sent SHALL set on app_wdf_wren && app_wdf_rdy; the two channels SHALL progress independently, in either order or the same cycle.
REQ-016 The phrase completes in the cycle where both channels are done (registered flag or same-cycle handshake); app_en and app_wdf_wren SHALL each be high for exactly one accepted handshake per phrase.
REQ-017 ready_in = calib_done_in && (state==IDLE || phrase completing this cycle); with both MIG ready signals held high, one phrase per cycle SHALL be sustained.
REQ-018 On completion without a new capture, return to IDLE; with a same-cycle capture, stay in ISSUE with the new phrase.
REQ-019 Next address = captured address + ADDR_INCR, computed in ADDR_WIDTH bits, modulo 2^ADDR_WIDTH; if the completed phrase index equals FRAME_PHRASES-1, next address = BASE_ADDR and next index = 0.
REQ-020 frame_done_out SHALL pulse in the cycle after the completion of the phrase with index FRAME_PHRASES-1.
REQ-021 tuser_in=1 mid-frame SHALL restart the frame: the phrase goes to BASE_ADDR and index 0, with no frame_done_out for the truncated frame.
REQ-022 Latency: app_en and app_wdf_wren SHALL assert in the cycle after capture; outputs are registered or decoded from state only, never combinationally from data_in.
REQ-023 calib_done_in=0 SHALL block new captures only; a phrase already in ISSUE SHALL complete.
REQ-024 app_addr and app_wdf_data SHALL hold stable from capture until completion.

Reset
REQ-025 On rst_in high, asynchronously: state IDLE, app_en 0, app_wdf_wren 0, app_wdf_end 0, frame_done_out 0, cmd_sent 0, data_sent 0, next address BASE_ADDR, index 0, app_addr BASE_ADDR, app_wdf_data 0.
REQ-026 ready_in SHALL be 0 while rst_in is high.
REQ-027 Reset during ISSUE SHALL abandon the held phrase immediately; the block does not retry it.

Verification
REQ-028 The bench SHALL cover: calib_done_in=1, app_rdy=app_wdf_rdy=1, 4 phrases with tuser_in on the first -> app_addr 0,8,16,24 on consecutive cycles; data matches in order.
REQ-029 The bench SHALL cover: app_rdy=0 for 3 cycles, app_wdf_rdy=1 -> data handshake in cycle 1, app_en held for 4 cycles, ready_in=0 until the command handshake; exactly one of each handshake.
REQ-030 The bench SHALL cover: FRAME_PHRASES=4, 6 phrases with tuser_in only on the first -> addresses 0,8,16,24,0,8; frame_done_out pulses once, the cycle after the 4th completion.
REQ-031 The bench SHALL cover: tuser_in on phrase 3 of a frame -> phrase 3 at address 0 and no frame_done_out for the first frame.
REQ-032 The bench SHALL cover: calib_done_in=0 with valid_in=1 -> ready_in=0 and no app_en; raising calib_done_in -> first write at BASE_ADDR.
REQ-033 The bench SHALL cover: rst_in asserted asynchronously mid-ISSUE -> app_en and app_wdf_wren drop before the next clock edge; the next frame starts at BASE_ADDR.
